alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
Parametrised successor to the single-cycle datapath adder. It adds an opcode set, a B-operand source select (register vs sign-extended immediate), status flags and a registered result. An optional iterative multiplier makes some ops multi-cycle, so the block uses a valid/ready handshake on both sides. It sits in the EX stage and is driven by control decode and the register file.

Parameters:
WIDTH, 8, datapath width in bits (must be at least 4).
OPW, 4, opcode width.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst_n  in  1  reset. One clock; reset is synchronous and active-low.
in_valid  in  1  operands and op are valid.
in_ready  out  1  block can accept an op this cycle.
op  in  OPW  operation select; encodings are in alu_pkg.
readdata1  in  WIDTH  operand A.
readdata2  in  WIDTH  register operand B.
sign_extended  in  WIDTH  immediate operand B.
alusrc  in  1  operand B select: 1 = sign_extended, 0 = readdata2.
out_valid  out  1  result and flags are valid.
out_ready  in  1  consumer accepts the result.
out  out  WIDTH  registered result.
zero  out  1  result equals 0.
carry  out  1  carry out of ADD; borrow of SUB/SLT; 0 for other ops.
overflow  out  1  signed overflow of ADD/SUB; 0 for other ops.

Behaviour:
- Reset (rst_n=0 at the clock edge): state goes to IDLE; out, zero, carry, overflow and out_valid all go to 0. in_ready=0 while rst_n=0.
- Accept: an op is taken when in_valid && in_ready. B = alusrc ? sign_extended : readdata2, captured at accept.
- in_ready = (state==IDLE) || (state==DONE && out_ready). This allows back-to-back issue.
- States:
  - IDLE: on accept of a single-cycle op, go to DONE; on accept of MUL, go to EXEC.
  - EXEC: run the iterative multiplier. After WIDTH cycles, go to DONE.
  - DONE: out_valid=1. If out_ready=0, hold. If out_ready=1 and a new accept occurs in the same cycle, go to DONE or EXEC as for IDLE; otherwise go to IDLE.
- Latency: single-cycle ops have out_valid one cycle after accept. MUL has out_valid WIDTH+1 cycles after accept.
- Ops (alu_pkg): ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5, SLL=6, SRL=7, SRA=8, MUL=9.
  - ADD/SUB use a WIDTH+1-bit sum. carry = bit WIDTH of A+B, or the borrow (A<B unsigned) for SUB.
  - overflow follows the standard two's-complement sign rule.
  - SLT returns 1 if signed A<B, else 0.
  - Shift amount = B[$clog2(WIDTH)-1:0]; upper bits of B are ignored.
  - MUL returns the low WIDTH bits of the unsigned product; carry=overflow=0.
  - zero = (out==0) for every op.
- Illegal op code (10..15, or MUL when compiled out): accepted like a single-cycle op; out=0, zero=1, other flags 0.
- While out_valid=1 and out_ready=0, out and flags are stable and all inputs are ignored.
- Reset mid-EXEC aborts the multiply. No result is produced for it.

Optional Feature:
ALU_MUL_EN.
- Defined: MUL implemented by the alu_mul_seq sub-module, shift-add, one bit per cycle, WIDTH cycles. The EXEC state exists.
- Undefined: no multiplier logic; MUL is treated as an illegal op (single cycle, out=0, zero=1). EXEC is unreachable and may be removed.

Decomposition:
- alu_pkg: opcode localparams, state encoding (IDLE/EXEC/DONE), and a function for the shift-amount width.
- One natural sub-module: alu_mul_seq (ports clk, rst_n, start, a, b, done, prod). Instantiated only under ALU_MUL_EN.
- Flag logic and the operand mux stay in alu_seq.

Test Plan (WIDTH=8):
- ADD: A=0x7F, readdata2=0x01, alusrc=0 -> out=0x80, overflow=1, carry=0, zero=0, one cycle after accept.
- SUB: A=0x05, B=0x07 -> out=0xFE, carry=1, overflow=0. Then SUB with A=0x07, B=0x07 -> out=0x00, zero=1.
- Immediate select: A=0x03, readdata2=0x10, sign_extended=0xFC, alusrc=1, ADD -> out=0xFF, carry=0. SRA with A=0x80, B=0x0B (amount 3) -> out=0xF0.
- MUL (ALU_MUL_EN defined): A=13, B=11 -> out=0x8F (143) exactly 9 cycles after accept, in_ready=0 throughout EXEC. Without the macro -> out=0, zero=1 after 1 cycle.
- Back-pressure and back-to-back:
  - Hold out_ready=0 for 5 cycles -> out and flags stay constant, in_ready=0.
  - Raise out_ready with in_valid=1 (AND 0xF0&0x3C) -> next cycle out=0x30, no idle bubble.
- Reset mid-MUL: assert rst_n=0 for 1 cycle at EXEC cycle 4 -> next cycle out=0, out_valid=0, state IDLE. A following ADD 1+1 -> out=0x02.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM state type and sizing helper for the alu_seq EX-stage ALU.
package alu_pkg;

  localparam int OP_ADD = 0;
  localparam int OP_SUB = 1;
  localparam int OP_AND = 2;
  localparam int OP_OR  = 3;
  localparam int OP_XOR = 4;
  localparam int OP_SLT = 5;
  localparam int OP_SLL = 6;
  localparam int OP_SRL = 7;
  localparam int OP_SRA = 8;
  localparam int OP_MUL = 9;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  // Only the low bits of B that can address a bit position act as the shift amount.
  function automatic int shamt_w(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add unsigned multiplier, one multiplier bit per cycle, WIDTH cycles after start.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] prod
);

  localparam int CW = $clog2(WIDTH);

  logic             busy;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mcand, mplier, acc, acc_nxt;

  assign acc_nxt = acc + (mplier[0] ? mcand : '0);
  // done flags the final step; prod is the accumulator after that step.
  assign done    = busy && (cnt == CW'(WIDTH-1));
  assign prod    = acc_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= '0;
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
    end else if (busy) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// EX-stage ALU with valid/ready handshake, registered result and flags.
// Define ALU_MUL_EN to build the iterative multiplier; otherwise MUL is an illegal op.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] readdata1,
  input  logic [WIDTH-1:0] readdata2,
  input  logic [WIDTH-1:0] sign_extended,
  input  logic             alusrc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             carry,
  output logic             overflow
);

  localparam int SHW = shamt_w(WIDTH);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] b, res, mul_prod;
  logic [WIDTH:0]   sum;
  logic [SHW-1:0]   sh;
  logic             res_c, res_v, accept, is_mul, mul_done;

  assign b         = alusrc ? sign_extended : readdata2;
  assign sh        = b[SHW-1:0];
  assign in_ready  = rst_n && ((state == S_IDLE) || (state == S_DONE && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == S_DONE);

`ifdef ALU_MUL_EN
  assign is_mul = (op == OPW'(OP_MUL));

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (accept && is_mul),
    .a     (readdata1),
    .b     (b),
    .done  (mul_done),
    .prod  (mul_prod)
  );
`else
  assign is_mul   = 1'b0;
  assign mul_done = 1'b0;
  assign mul_prod = '0;
`endif

  // Single-cycle ops; MUL and unknown codes fall to the zero default.
  always_comb begin
    res   = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    sum   = '0;
    case (op)
      OPW'(OP_ADD): begin
        sum   = {1'b0, readdata1} + {1'b0, b};
        res   = sum[WIDTH-1:0];
        res_c = sum[WIDTH];
        res_v = (readdata1[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != readdata1[WIDTH-1]);
      end
      OPW'(OP_SUB): begin
        sum   = {1'b0, readdata1} - {1'b0, b};
        res   = sum[WIDTH-1:0];
        res_c = sum[WIDTH];
        res_v = (readdata1[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != readdata1[WIDTH-1]);
      end
      OPW'(OP_AND): res = readdata1 & b;
      OPW'(OP_OR):  res = readdata1 | b;
      OPW'(OP_XOR): res = readdata1 ^ b;
      OPW'(OP_SLT): begin
        sum   = {1'b0, readdata1} - {1'b0, b};
        res   = {{(WIDTH-1){1'b0}}, ($signed(readdata1) < $signed(b))};
        res_c = sum[WIDTH];
      end
      OPW'(OP_SLL): res = readdata1 << sh;
      OPW'(OP_SRL): res = readdata1 >> sh;
      OPW'(OP_SRA): res = $signed(readdata1) >>> sh;
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (accept)                          state_nxt = is_mul ? S_EXEC : S_DONE;
        else if (state == S_DONE && out_ready) state_nxt = S_IDLE;
      end
      S_EXEC:  if (mul_done) state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      out      <= '0;
      zero     <= 1'b0;
      carry    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept && !is_mul) begin
        out      <= res;
        zero     <= (res == '0);
        carry    <= res_c;
        overflow <= res_v;
      end else if (state == S_EXEC && mul_done) begin
        out      <= mul_prod;
        zero     <= (mul_prod == '0);
        carry    <= 1'b0;
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: arithmetic reference model + scoreboard checked every cycle.
module tb_alu_seq;

  localparam int W   = 8;
  localparam int OPW = 4;
  localparam longint M = longint'(1) << W;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [OPW-1:0] op = '0;
  logic [W-1:0]   readdata1 = '0, readdata2 = '0, sign_extended = '0;
  logic           alusrc = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [W-1:0]   out;
  logic           zero, carry, overflow;

  int tests = 0;
  int errs  = 0;
  int cyc   = 0;

  typedef struct {
    logic [W-1:0] out;
    logic         z, c, v;
    int           lat;
    int           acc_cyc;
  } exp_t;

  exp_t q[$];
  bit   rst_chk = 1'b0;

  alu_seq #(.WIDTH(W), .OPW(OPW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .readdata1(readdata1), .readdata2(readdata2), .sign_extended(sign_extended),
    .alusrc(alusrc), .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .zero(zero), .carry(carry), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Result computed from the op definitions with signed/unsigned integer arithmetic.
  function automatic exp_t model(input int o, input logic [W-1:0] a, input logic [W-1:0] bb);
    exp_t   e;
    longint ua, ub, sa, sb, r, s;
    int     sh;
    ua = longint'(a);
    ub = longint'(bb);
    sa = a[W-1]  ? ua - M : ua;
    sb = bb[W-1] ? ub - M : ub;
    sh = int'(ub % W);
    r = 0; e.c = 1'b0; e.v = 1'b0; e.lat = 1; e.acc_cyc = 0;
    case (o)
      0: begin r = ua + ub; e.c = (r >= M); s = sa + sb; e.v = (s > M/2 - 1) || (s < -(M/2)); end
      1: begin r = ua - ub; e.c = (ua < ub); s = sa - sb; e.v = (s > M/2 - 1) || (s < -(M/2)); end
      2: r = longint'(a & bb);
      3: r = longint'(a | bb);
      4: r = longint'(a ^ bb);
      5: begin r = (sa < sb) ? 1 : 0; e.c = (ua < ub); end
      6: r = ua * (longint'(1) << sh);
      7: r = ua / (longint'(1) << sh);
      8: r = sa >>> sh;
`ifdef ALU_MUL_EN
      9: begin r = ua * ub; e.lat = W + 1; end
`endif
      default: r = 0;
    endcase
    e.out = W'(r);
    e.z   = (e.out == '0);
    return e;
  endfunction

  task automatic pin(input string name, input int o, input logic [W-1:0] a, input logic [W-1:0] bb,
                     input logic [W-1:0] eo, input logic ez, input logic ec, input logic ev);
    exp_t e;
    e = model(o, a, bb);
    chk({name, "_out"}, longint'(e.out), longint'(eo));
    chk({name, "_flags"}, longint'({e.z, e.c, e.v}), longint'({ez, ec, ev}));
  endtask

  // Scoreboard: check handshake every cycle, result whenever valid, then advance the model.
  always @(negedge clk) begin : compare
    bit eov, eir;
    eov = (q.size() > 0) && (cyc - q[0].acc_cyc >= q[0].lat);
    eir = rst_n && ((q.size() == 0) || (eov && out_ready));
    chk("out_valid", longint'(out_valid), longint'(eov));
    chk("in_ready", longint'(in_ready), longint'(eir));
    if (eov && out_valid) begin
      chk("out", longint'(out), longint'(q[0].out));
      chk("flags_zcv", longint'({zero, carry, overflow}), longint'({q[0].z, q[0].c, q[0].v}));
    end
    if (rst_chk) begin
      chk("reset_state", longint'({out, zero, carry, overflow, out_valid}), 0);
      rst_chk = 1'b0;
    end
    if (!rst_n) begin
      q.delete();
      rst_chk = 1'b1;
    end else begin
      if (eov && out_ready) void'(q.pop_front());
      if (in_valid && eir) begin
        exp_t e;
        e = model(int'(op), readdata1, alusrc ? sign_extended : readdata2);
        e.acc_cyc = cyc;
        q.push_back(e);
      end
    end
  end

  task automatic issue(input int o, input logic [W-1:0] a, input logic [W-1:0] rd2,
                       input logic [W-1:0] imm, input logic src);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    op = OPW'(o); readdata1 = a; readdata2 = rd2; sign_extended = imm; alusrc = src;
    in_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Literal pins on the reference model.
    pin("add_ovf", 0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1);
    pin("sub_brw", 1, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b1, 1'b0);
    pin("sub_eq",  1, 8'h07, 8'h07, 8'h00, 1'b1, 1'b0, 1'b0);
    pin("add_imm", 0, 8'h03, 8'hFC, 8'hFF, 1'b0, 1'b0, 1'b0);
    pin("sra",     8, 8'h80, 8'h0B, 8'hF0, 1'b0, 1'b0, 1'b0);
    pin("and",     2, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0);
    pin("slt",     5, 8'hFF, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0);
    pin("illegal", 12, 8'h55, 8'h66, 8'h00, 1'b1, 1'b0, 1'b0);
`ifdef ALU_MUL_EN
    pin("mul",     9, 8'd13, 8'd11, 8'h8F, 1'b0, 1'b0, 1'b0);
`else
    pin("mul_off", 9, 8'd13, 8'd11, 8'h00, 1'b1, 1'b0, 1'b0);
`endif

    idle(2);
    rst_n = 1'b1;
    idle(1);

    issue(0, 8'h7F, 8'h01, 8'h00, 1'b0);
    issue(1, 8'h05, 8'h07, 8'h00, 1'b0);
    issue(1, 8'h07, 8'h07, 8'h00, 1'b0);
    issue(0, 8'h03, 8'h10, 8'hFC, 1'b1);
    issue(8, 8'h80, 8'h0B, 8'h00, 1'b0);
    issue(9, 8'd13, 8'd11, 8'h00, 1'b0);
    idle(12);

    // Back-pressure: result held 5 cycles while a pending AND waits, then issues back-to-back.
    out_ready = 1'b0;
    issue(0, 8'h12, 8'h34, 8'h00, 1'b0);
    op = OPW'(2); readdata1 = 8'hF0; readdata2 = 8'h3C; alusrc = 1'b0; in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      sign_extended = W'($urandom);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_out", longint'(out), 8'h30);
    chk("b2b_valid", longint'(out_valid), 1);
    idle(3);

    // Reset during the fourth EXEC cycle of a multiply.
    issue(9, 8'd13, 8'd11, 8'h00, 1'b0);
    idle(2);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mul_out", longint'(out), 0);
    chk("rst_mul_valid", longint'(out_valid), 0);
    issue(0, 8'h01, 8'h01, 8'h00, 1'b0);
    @(negedge clk);
    chk("post_rst_add", longint'(out), 8'h02);
    idle(2);

    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      op            = OPW'($urandom_range(0, 15));
      readdata1     = W'($urandom);
      readdata2     = W'($urandom);
      sign_extended = W'($urandom);
      alusrc        = 1'($urandom);
      in_valid      = ($urandom_range(0, 1) == 1);
      out_ready     = ($urandom_range(0, 9) < 7);
      rst_n         = ($urandom_range(0, 79) != 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1; rst_n = 1'b1;
    idle(15);

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

endmodule
